// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the reference-clock domain: pulses the PLL reset,
// qualifies lock stability, gates the core reset and logs loss/timeout events.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOSS_W              = 8
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              relock_req,
  input  logic              clr_status,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic              ready,
  output logic              timeout_err,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [1:0] ST_PLL_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_lock_s;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_loss;
  logic                   w_timeout;
  logic                   r_pll_rst;
  logic                   r_sys_reset_n;
  logic                   r_ready;
  logic                   r_timeout_err;
  logic [LOSS_W-1:0]      r_loss_count;

  // NOTE: reset asserts asynchronously but is released only after two refclk
  // edges, so no flop sees a reset removal close to its clock edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) r_lock_sync <= '0;
    else          r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
  end
  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_loss      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_PLL_RESET: begin
        if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_PLL_RESET;
          w_timeout   = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s)                                     w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1))  w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A loss takes priority over a coincident relock request so it is counted.
        if (!w_lock_s) begin
          w_state_nxt = ST_PLL_RESET;
          w_loss      = 1'b1;
        end else if (relock_req) begin
          w_state_nxt = ST_PLL_RESET;
        end
      end
      default: w_state_nxt = ST_PLL_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_PLL_RESET;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != ST_RUN) r_cnt <= r_cnt + CNT_W'(1);
      r_pll_rst     <= (w_state_nxt == ST_PLL_RESET);
      r_sys_reset_n <= (w_state_nxt == ST_RUN);
      r_ready       <= (w_state_nxt == ST_RUN);
    end
  end

  // Status: a new event on the same edge as clr_status wins over the clear.
  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_timeout_err <= 1'b0;
      r_loss_count  <= '0;
    end else begin
      if (w_timeout)       r_timeout_err <= 1'b1;
      else if (clr_status) r_timeout_err <= 1'b0;

      if (w_loss) begin
        if (clr_status)         r_loss_count <= LOSS_W'(1);
        else if (!(&r_loss_count)) r_loss_count <= r_loss_count + LOSS_W'(1);
      end else if (clr_status) begin
        r_loss_count <= '0;
      end
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset_n = r_sys_reset_n;
  assign ready       = r_ready;
  assign timeout_err = r_timeout_err;
  assign loss_count  = r_loss_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed + randomized bench for pll_lock_sequencer, checked every cycle
// against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int SYNC     = 2;
  localparam int PLL_RST  = 4;
  localparam int STABLE   = 8;
  localparam int TIMEOUT  = 40;
  localparam int LOSS_W   = 8;
  localparam int RST_SYNC = 2;
  localparam int LOSS_MAX = (1 << LOSS_W) - 1;

  logic              refclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_locked = 1'b1;
  logic              relock_req = 1'b0;
  logic              clr_status = 1'b0;
  logic              pll_rst;
  logic              sys_reset_n;
  logic              ready;
  logic              timeout_err;
  logic [LOSS_W-1:0] loss_count;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PLL_RST), .LOCK_STABLE_CYCLES(STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT), .LOSS_W(LOSS_W)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .clr_status(clr_status), .pll_rst(pll_rst), .sys_reset_n(sys_reset_n),
    .ready(ready), .timeout_err(timeout_err), .loss_count(loss_count)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: which phase the controller is in and how long it has been there.
  typedef enum {M_RESETTING, M_WAITING, M_SETTLING, M_RUNNING} mphase_t;
  mphase_t m_phase;
  int      m_elapsed;
  int      m_hold;
  int      m_loss;
  bit      m_timeout;
  bit      m_lock_q[$];

  task automatic enter(input mphase_t p);
    m_phase   = p;
    m_elapsed = 0;
  endtask

  task automatic model_reset();
    enter(M_RESETTING);
    m_loss    = 0;
    m_timeout = 1'b0;
    m_lock_q.delete();
  endtask

  task automatic model_step();
    bit lock_seen;
    bit loss_ev;
    bit to_ev;
    if (!rst_n) begin
      model_reset();
      m_hold = RST_SYNC;
      return;
    end
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    lock_seen = (m_lock_q.size() >= SYNC) ? m_lock_q[0] : 1'b0;
    m_lock_q.push_back(pll_locked);
    if (m_lock_q.size() > SYNC) void'(m_lock_q.pop_front());
    loss_ev = 1'b0;
    to_ev   = 1'b0;
    case (m_phase)
      M_RESETTING: begin
        m_elapsed++;
        if (m_elapsed == PLL_RST) enter(M_WAITING);
      end
      M_WAITING: begin
        if (lock_seen) enter(M_SETTLING);
        else begin
          m_elapsed++;
          if (m_elapsed == TIMEOUT) begin
            to_ev = 1'b1;
            enter(M_RESETTING);
          end
        end
      end
      M_SETTLING: begin
        if (!lock_seen) enter(M_WAITING);
        else begin
          m_elapsed++;
          if (m_elapsed == STABLE) enter(M_RUNNING);
        end
      end
      M_RUNNING: begin
        if (!lock_seen) begin
          loss_ev = 1'b1;
          enter(M_RESETTING);
        end else if (relock_req) begin
          enter(M_RESETTING);
        end
      end
      default: enter(M_RESETTING);
    endcase
    if (to_ev) m_timeout = 1'b1;
    else if (clr_status) m_timeout = 1'b0;
    if (loss_ev) m_loss = clr_status ? 1 : ((m_loss == LOSS_MAX) ? LOSS_MAX : m_loss + 1);
    else if (clr_status) m_loss = 0;
  endtask

  // One refclk edge: update the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check("cyc_pll_rst", pll_rst, m_phase == M_RESETTING);
    check("cyc_sys_reset_n", sys_reset_n, m_phase == M_RUNNING);
    check("cyc_ready", ready, m_phase == M_RUNNING);
    check("cyc_timeout_err", timeout_err, m_timeout);
    check("cyc_loss_count", loss_count, m_loss);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until the selected output (0: pll_rst, 1: ready) reaches lvl; n = edges taken.
  task automatic wait_for(input string tag, input int sel, input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((((sel == 0) ? pll_rst : ready) !== lvl) && n < 300);
    if (((sel == 0) ? pll_rst : ready) !== lvl) check(tag, (sel == 0) ? pll_rst : ready, lvl);
  endtask

  initial begin
    int n;
    int rises[$];
    bit ready_seen;
    logic prev_rst;
    int hold_left;

    model_reset();
    m_hold = RST_SYNC;

    // 1: power-up with lock already present
    ticks(3);
    check("t1_reset_pll_rst", pll_rst, 1'b1);
    check("t1_reset_ready", ready, 1'b0);
    rst_n = 1'b1;
    wait_for("t1_to_wait", 0, 1'b0, n);
    check("t1_pll_rst_dwell", n, RST_SYNC + PLL_RST);
    wait_for("t1_to_run", 1, 1'b1, n);
    check("t1_ready_latency", n, 1 + STABLE);
    check("t1_sys_reset_n", sys_reset_n, 1'b1);
    check("t1_timeout_err", timeout_err, 1'b0);

    // 2: lock absent -> periodic re-reset with timeout flag, then lock arrives
    pll_locked = 1'b0;
    ready_seen = 1'b0;
    prev_rst   = pll_rst;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (pll_rst && !prev_rst) rises.push_back(i);
      if (ready && i > SYNC + 1) ready_seen = 1'b1;
      prev_rst = pll_rst;
    end
    check("t2_rise_count", rises.size() >= 3, 1'b1);
    if (rises.size() >= 3) begin
      check("t2_period_a", rises[1] - rises[0], PLL_RST + TIMEOUT);
      check("t2_period_b", rises[2] - rises[1], PLL_RST + TIMEOUT);
    end
    check("t2_ready_never", ready_seen, 1'b0);
    check("t2_timeout_err", timeout_err, 1'b1);
    check("t2_loss_once", loss_count, 1);
    wait_for("t2_pulse_hi", 0, 1'b1, n);
    wait_for("t2_pulse_lo", 0, 1'b0, n);
    ticks(5);
    pll_locked = 1'b1;
    wait_for("t2_to_run", 1, 1'b1, n);
    check("t2_ready_latency", n, SYNC + 1 + STABLE);

    // 3: lock glitch during the stability window
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_for("t3_to_wait", 0, 1'b0, n);
    tick();
    ticks(5);
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    wait_for("t3_to_run", 1, 1'b1, n);
    check("t3_ready_latency", n, SYNC + 1 + STABLE);
    check("t3_loss_unchanged", loss_count, 1);

    // 4: losses in RUN, up to saturation
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t4_clr_loss", loss_count, 0);
    check("t4_clr_timeout", timeout_err, 1'b0);
    pll_locked = 1'b0;
    ticks(SYNC);
    check("t4_ready_before", ready, 1'b1);
    tick();
    check("t4_ready_drop", ready, 1'b0);
    check("t4_sysn_drop", sys_reset_n, 1'b0);
    check("t4_pll_rst_rise", pll_rst, 1'b1);
    check("t4_loss_one", loss_count, 1);
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b1;
      wait_for("t4_loop_run", 1, 1'b1, n);
      pll_locked = 1'b0;
      wait_for("t4_loop_loss", 1, 1'b0, n);
    end
    check("t4_loss_saturated", loss_count, LOSS_MAX);

    // 5: relock requests and clear/event collisions
    clr_status = 1'b1;
    pll_locked = 1'b1;
    tick();
    clr_status = 1'b0;
    wait_for("t5_to_run", 1, 1'b1, n);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("t5_relock_rise", pll_rst, 1'b1);
    wait_for("t5_relock_fall", 0, 1'b0, n);
    check("t5_relock_dwell", n, PLL_RST);
    check("t5_relock_no_loss", loss_count, 0);
    wait_for("t5_to_run2", 1, 1'b1, n);
    pll_locked = 1'b0;
    ticks(SYNC);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("t5_relock_loss", loss_count, 1);
    pll_locked = 1'b1;
    wait_for("t5_to_run3", 1, 1'b1, n);
    pll_locked = 1'b0;
    ticks(SYNC);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t5_clr_with_loss", loss_count, 1);
    wait_for("t5_to_wait", 0, 1'b0, n);
    ticks(TIMEOUT - 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t5_clr_with_timeout", timeout_err, 1'b1);
    check("t5_clr_loss_cleared", loss_count, 0);

    // 6: asynchronous reset in the middle of STABLE
    pll_locked = 1'b1;
    wait_for("t6_to_wait", 0, 1'b0, n);
    ticks(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pll_rst", pll_rst, 1'b1);
    check("t6_async_sysn", sys_reset_n, 1'b0);
    check("t6_async_ready", ready, 1'b0);
    check("t6_async_timeout", timeout_err, 1'b0);
    check("t6_async_loss", loss_count, 0);
    @(negedge refclk);
    ticks(2);
    rst_n = 1'b1;
    wait_for("t6_to_wait2", 0, 1'b0, n);
    check("t6_pll_rst_dwell", n, RST_SYNC + PLL_RST);
    wait_for("t6_to_run", 1, 1'b1, n);
    check("t6_ready_latency", n, 1 + STABLE);

    // Random lock behaviour with sporadic relock and clear requests
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        pll_locked = ~pll_locked;
        hold_left  = pll_locked ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 50));
      end
      hold_left--;
      relock_req = ($urandom_range(0, 15) == 0);
      clr_status = ($urandom_range(0, 31) == 0);
      tick();
    end
    relock_req = 1'b0;
    clr_status = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
